gate_vector_checker: RTL



---
 rtl/gate_vector_checker.sv | 124 ++++++++++++
 1 files changed

// File: rtl/gate_vector_checker.sv
// rtl/gate_vector_checker.sv - stimulus generator and truth-table checker for a single-output logic gate
// Walks every input vector in ascending order, samples dut_y after SETTLE cycles and tallies mismatches.
module gate_vector_checker #(
  parameter int                 N_IN   = 1,
  parameter int                 SETTLE = 2,
  parameter logic [2**N_IN-1:0] TRUTH  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_y,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0]      CNT_LOAD = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] STIM_ONE = N_IN'(1);
  localparam logic [N_IN-1:0] STIM_LAST = '1;
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   fvec_q, fvec_d;
  logic              fvalid_q, fvalid_d;
  logic              pass_q, pass_d;
  logic              mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      stim_q   <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      fvec_q   <= '0;
      fvalid_q <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      fvec_q   <= fvec_d;
      fvalid_q <= fvalid_d;
      pass_q   <= pass_d;
    end
  end

  // An unknown dut_y fails the equality test and therefore counts as a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if (dut_y == TRUTH[stim_q]) mismatch = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fvec_d   = fvec_q;
    fvalid_d = fvalid_q;
    pass_d   = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          stim_d   = '0;
          cnt_d    = CNT_LOAD;
          err_d    = '0;
          fvec_d   = '0;
          fvalid_d = 1'b0;
          pass_d   = 1'b0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (mismatch) begin
            err_d = err_q + ERR_ONE;
            if (!fvalid_q) begin
              fvec_d   = stim_q;
              fvalid_d = 1'b1;
            end
          end
          if (stim_q != STIM_LAST) begin
            stim_d = stim_q + STIM_ONE;
            cnt_d  = CNT_LOAD;
          end else begin
            // err_d already includes a mismatch on the final vector.
            pass_d  = (err_d == '0);
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_WAIT);
    done = (state_q == S_DONE);
  end

  assign stim       = stim_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fvec_q;
  assign fail_valid = fvalid_q;

endmodule
